// File: rtl/operand_fifo_writer.sv
// Producer for the A/B operand FIFOs feeding the dot-product MAC.
// Each channel writes DEPTH arithmetic-sequence values under its own full flag.
module operand_fifo_writer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned A_BASE     = 0,
  parameter int unsigned A_STEP     = 5,
  parameter int unsigned B_BASE     = 0,
  parameter int unsigned B_STEP     = 10,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         a_full,
  input  logic                         b_full,
  output logic                         a_wren,
  output logic [DATA_WIDTH-1:0]        a_wdata,
  output logic                         b_wren,
  output logic [DATA_WIDTH-1:0]        b_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   a_count,
  output logic [$clog2(DEPTH+1)-1:0]   b_count,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0]         DepthCnt = CW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] ABase    = DATA_WIDTH'(A_BASE);
  localparam logic [DATA_WIDTH-1:0] AStep    = DATA_WIDTH'(A_STEP);
  localparam logic [DATA_WIDTH-1:0] BBase    = DATA_WIDTH'(B_BASE);
  localparam logic [DATA_WIDTH-1:0] BStep    = DATA_WIDTH'(B_STEP);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic                    reload;
  logic [CW-1:0]           a_count_q, a_count_d;
  logic [CW-1:0]           b_count_q, b_count_d;
  logic [DATA_WIDTH-1:0]   a_val_q, a_val_d;
  logic [DATA_WIDTH-1:0]   b_val_q, b_val_d;

  // Channels advance independently; a value only moves on after it was written.
  always_comb begin
    a_wren    = (state_q == StFill) && !a_full && (a_count_q < DepthCnt);
    b_wren    = (state_q == StFill) && !b_full && (b_count_q < DepthCnt);
    a_count_d = a_count_q;
    a_val_d   = a_val_q;
    b_count_d = b_count_q;
    b_val_d   = b_val_q;
    if (reload) begin
      a_count_d = '0;
      a_val_d   = ABase;
      b_count_d = '0;
      b_val_d   = BBase;
    end else begin
      if (a_wren) begin
        a_count_d = a_count_q + 1'b1;
        a_val_d   = a_val_q + AStep;
      end
      if (b_wren) begin
        b_count_d = b_count_q + 1'b1;
        b_val_d   = b_val_q + BStep;
      end
    end
  end

  // Leave FILL on the edge that completes the last write, so done follows directly.
  always_comb begin
    state_d = state_q;
    reload  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (AUTO_START || start) state_d = StFill;
      end
      StFill: begin
        if ((a_count_d == DepthCnt) && (b_count_d == DepthCnt)) state_d = StDone;
      end
      StDone: begin
        if (start) begin
          state_d = StFill;
          reload  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_count_q <= '0;
      b_count_q <= '0;
      a_val_q   <= ABase;
      b_val_q   <= BBase;
    end else begin
      state_q   <= state_d;
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
      a_val_q   <= a_val_d;
      b_val_q   <= b_val_d;
    end
  end

  assign a_wdata = a_val_q;
  assign b_wdata = b_val_q;
  assign a_count = a_count_q;
  assign b_count = b_count_q;
  assign busy    = (state_q == StFill);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_operand_fifo_writer.sv
// Directed bench for operand_fifo_writer: default instance plus an A_STEP=40,
// start-driven instance for wrap-around and IDLE-wait behaviour.
module tb_operand_fifo_writer;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n  = 1'b1;
  logic       start  = 1'b0;
  logic       a_full = 1'b0;
  logic       b_full = 1'b0;
  logic       a_wren, b_wren, busy, done;
  logic [7:0] a_wdata, b_wdata;
  logic [3:0] a_count, b_count;

  logic       start2  = 1'b0;
  logic       s_a_full = 1'b0;
  logic       s_b_full = 1'b0;
  logic       s_a_wren, s_b_wren, s_busy, s_done;
  logic [7:0] s_a_wdata, s_b_wdata;
  logic [3:0] s_a_count, s_b_count;

  int n_checks = 0;
  int n_fail   = 0;

  operand_fifo_writer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_full  (a_full),
    .b_full  (b_full),
    .a_wren  (a_wren),
    .a_wdata (a_wdata),
    .b_wren  (b_wren),
    .b_wdata (b_wdata),
    .a_count (a_count),
    .b_count (b_count),
    .busy    (busy),
    .done    (done)
  );

  operand_fifo_writer #(
    .A_STEP     (40),
    .AUTO_START (1'b0)
  ) dut_s40 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start2),
    .a_full  (s_a_full),
    .b_full  (s_b_full),
    .a_wren  (s_a_wren),
    .a_wdata (s_a_wdata),
    .b_wren  (s_b_wren),
    .b_wdata (s_b_wdata),
    .a_count (s_a_count),
    .b_count (s_b_count),
    .busy    (s_busy),
    .done    (s_done)
  );

  // Ends on a falling edge with rst_n released; the next rising edge is cycle 1.
  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #5 rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_wren, b_wren, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {a_wren, b_wren, busy, done});
    end
    n_checks++;
    if ({a_wdata, b_wdata} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_wdata: got %h expected 0000", {a_wdata, b_wdata});
    end
    n_checks++;
    if ({a_count, b_count} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_counts: got %h expected 00", {a_count, b_count});
    end
    n_checks++;
    if ({s_a_wren, s_b_wren, s_busy, s_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_s40_flags: got %b expected 0000", {s_a_wren, s_b_wren, s_busy, s_done});
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp_a, exp_b;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c <= 8) begin
        exp_a = 8'(5 * (c - 1));
        exp_b = 8'(10 * (c - 1));
        n_checks++;
        if ({a_wren, b_wren, busy, done} !== 4'b1110) begin
          n_fail++;
          $display("FAIL fill_flags c%0d: got %b expected 1110", c, {a_wren, b_wren, busy, done});
        end
        n_checks++;
        if (a_wdata !== exp_a) begin
          n_fail++;
          $display("FAIL fill_a_wdata c%0d: got %0d expected %0d", c, a_wdata, exp_a);
        end
        n_checks++;
        if (b_wdata !== exp_b) begin
          n_fail++;
          $display("FAIL fill_b_wdata c%0d: got %0d expected %0d", c, b_wdata, exp_b);
        end
      end else begin
        n_checks++;
        if ({a_wren, b_wren, busy, done} !== 4'b0001) begin
          n_fail++;
          $display("FAIL fill_done_flags: got %b expected 0001", {a_wren, b_wren, busy, done});
        end
        n_checks++;
        if ({a_count, b_count} !== {4'd8, 4'd8}) begin
          n_fail++;
          $display("FAIL fill_done_counts: got %h expected 88", {a_count, b_count});
        end
      end
      n_checks++;
      if ({s_a_wren, s_busy, s_done} !== 3'b000) begin
        n_fail++;
        $display("FAIL s40_waits_idle c%0d: got %b expected 000", c, {s_a_wren, s_busy, s_done});
      end
    end
  endtask

  task automatic test_backpressure();
    int   ai, bi;
    logic e_busy, e_aw, e_bw;
    ai = 0;
    bi = 0;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1 a_full = (c >= 3) && (c <= 5);
      @(negedge clk);
      e_busy = (c <= 11);
      e_aw   = e_busy && !a_full && (ai < 8);
      e_bw   = e_busy && (bi < 8);
      n_checks++;
      if ({a_wren, b_wren, busy, done} !== {e_aw, e_bw, e_busy, !e_busy}) begin
        n_fail++;
        $display("FAIL bp_flags c%0d: got %b expected %b", c, {a_wren, b_wren, busy, done},
                 {e_aw, e_bw, e_busy, !e_busy});
      end
      n_checks++;
      if ({a_wdata, b_wdata} !== {8'(5 * ai), 8'(10 * bi)}) begin
        n_fail++;
        $display("FAIL bp_wdata c%0d: got %0d/%0d expected %0d/%0d", c, a_wdata, b_wdata,
                 5 * ai, 10 * bi);
      end
      n_checks++;
      if ({a_count, b_count} !== {4'(ai), 4'(bi)}) begin
        n_fail++;
        $display("FAIL bp_counts c%0d: got %0d/%0d expected %0d/%0d", c, a_count, b_count,
                 ai, bi);
      end
      if (e_aw) ai++;
      if (e_bw) bi++;
    end
    a_full = 1'b0;
  endtask

  task automatic test_restart();
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b01) begin
      n_fail++;
      $display("FAIL restart_pre: got %b expected 01", {busy, done});
    end
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1 start = (k == 3);
      @(negedge clk);
      if (k <= 8) begin
        n_checks++;
        if ({a_wren, b_wren, busy, done} !== 4'b1110) begin
          n_fail++;
          $display("FAIL restart_flags k%0d: got %b expected 1110", k, {a_wren, b_wren, busy, done});
        end
        n_checks++;
        if ({a_wdata, b_wdata} !== {8'(5 * (k - 1)), 8'(10 * (k - 1))}) begin
          n_fail++;
          $display("FAIL restart_wdata k%0d: got %0d/%0d expected %0d/%0d", k, a_wdata,
                   b_wdata, 5 * (k - 1), 10 * (k - 1));
        end
        n_checks++;
        if (a_count !== 4'(k - 1)) begin
          n_fail++;
          $display("FAIL restart_count k%0d: got %0d expected %0d", k, a_count, k - 1);
        end
      end else begin
        n_checks++;
        if ({busy, done} !== 2'b01) begin
          n_fail++;
          $display("FAIL restart_done: got %b expected 01", {busy, done});
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk);
      #1 start2 = (k == 0);
      @(negedge clk);
      if (k == 0) begin
        n_checks++;
        if ({s_a_wren, s_busy} !== 2'b00) begin
          n_fail++;
          $display("FAIL wrap_idle: got %b expected 00", {s_a_wren, s_busy});
        end
      end else if (k <= 8) begin
        n_checks++;
        if ({s_a_wren, s_b_wren, s_busy} !== 3'b111) begin
          n_fail++;
          $display("FAIL wrap_flags k%0d: got %b expected 111", k, {s_a_wren, s_b_wren, s_busy});
        end
        n_checks++;
        if (s_a_wdata !== 8'(40 * (k - 1))) begin
          n_fail++;
          $display("FAIL wrap_a_wdata k%0d: got %0d expected %0d", k, s_a_wdata,
                   (40 * (k - 1)) % 256);
        end
        if (k == 8) begin
          n_checks++;
          if (s_a_wdata !== 8'd24) begin
            n_fail++;
            $display("FAIL wrap_last: got %0d expected 24", s_a_wdata);
          end
        end
      end else begin
        n_checks++;
        if ({s_done, s_a_count} !== {1'b1, 4'd8}) begin
          n_fail++;
          $display("FAIL wrap_done: got %b/%0d expected 1/8", s_done, s_a_count);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (a_count !== 4'd4) begin
      n_fail++;
      $display("FAIL mid_pre_count: got %0d expected 4", a_count);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_wren, b_wren, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_flags: got %b expected 0000", {a_wren, b_wren, busy, done});
    end
    n_checks++;
    if ({a_count, b_count, a_wdata, b_wdata} !== 24'h0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got %h expected 000000", {a_count, b_count, a_wdata, b_wdata});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (c <= 8) begin
        if ({a_wren, a_wdata} !== {1'b1, 8'(5 * (c - 1))}) begin
          n_fail++;
          $display("FAIL mid_refill c%0d: got %b/%0d expected 1/%0d", c, a_wren, a_wdata,
                   5 * (c - 1));
        end
      end else if (done !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_refill_done: got %b expected 1", done);
      end
    end
  endtask

  task automatic test_full_stall();
    a_full = 1'b1;
    b_full = 1'b1;
    do_reset();
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({a_wren, b_wren, busy, done, a_count, b_count} !== {4'b0010, 8'h00}) begin
        n_fail++;
        $display("FAIL stall c%0d: got %b/%h expected 0010/00", c,
                 {a_wren, b_wren, busy, done}, {a_count, b_count});
      end
    end
    for (int j = 1; j <= 9; j++) begin
      @(posedge clk);
      if (j == 1) begin
        #1;
        a_full = 1'b0;
        b_full = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (j <= 8) begin
        if ({a_wren, b_wren, b_wdata} !== {2'b11, 8'(10 * (j - 1))}) begin
          n_fail++;
          $display("FAIL stall_release j%0d: got %b/%0d expected 11/%0d", j,
                   {a_wren, b_wren}, b_wdata, 10 * (j - 1));
        end
      end else if ({busy, done} !== 2'b01) begin
        n_fail++;
        $display("FAIL stall_done: got %b expected 01", {busy, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_restart();
    test_wrap();
    test_reset_mid();
    test_full_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
